// File: rtl/mio_fabric.sv
// CPU-side memory fabric: address decode to external slaves plus an internal
// register block holding scratch registers, a periodic timer, a keyboard FIFO and error capture.
module mio_fabric #(
  parameter int                 N_SLV          = 4,
  parameter logic [32*N_SLV-1:0] SLV_BASE      = {N_SLV{32'h0}},
  parameter logic [32*N_SLV-1:0] SLV_MASK      = {N_SLV{32'h0}},
  parameter logic [31:0]        REG_BASE       = 32'h0000_1000,
  parameter int                 N_SCR          = 4,
  parameter int                 KF_DEPTH       = 8,
  parameter logic [31:0]        TMR_RST_PERIOD = 32'd100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_a,
  input  logic [31:0]          d_t_mem,
  input  logic                 wmem,
  input  logic                 rmem,
  output logic [31:0]          d_f_mem,
  output logic [31:0]          slv_a,
  output logic [31:0]          slv_d,
  output logic [N_SLV-1:0]     slv_we,
  output logic [N_SLV-1:0]     slv_re,
  input  logic [32*N_SLV-1:0]  slv_rd,
  input  logic                 key_valid,
  input  logic [7:0]           key_data,
  output logic                 key_ready,
  output logic                 tick_irq,
  output logic                 bus_err
);

  localparam int PW = $clog2(KF_DEPTH);
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------- decode
  logic             reg_hit;
  logic [N_SLV-1:0] hit;
  logic [N_SLV-1:0] win;
  logic             miss;
  logic [3:0]       word;

  assign word = mem_a[5:2];

  always_comb begin
    logic found;
    found   = 1'b0;
    reg_hit = (mem_a[31:6] == REG_BASE[31:6]);
    hit     = '0;
    win     = '0;
    for (int i = 0; i < N_SLV; i++) begin
      hit[i] = ((mem_a & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]));
      win[i] = hit[i] & ~found & ~reg_hit;
      found  = found | hit[i];
    end
  end

  assign miss   = ~reg_hit & ~(|hit);
  assign slv_a  = mem_a;
  assign slv_d  = d_t_mem;
  assign slv_we = {N_SLV{wmem}} & win;
  assign slv_re = {N_SLV{rmem}} & win;

  // Simultaneous wmem/rmem counts as a write, so reads are gated by ~wmem.
  logic reg_wr;
  logic kd_rd;
  logic wr_period;
  logic wr_ctrl;
  logic w1c_tick;
  logic w1c_ovf;
  logic w1c_err;

  assign reg_wr    = wmem & reg_hit;
  assign kd_rd     = rmem & ~wmem & reg_hit & (word == 4'hC);
  assign wr_period = reg_wr & (word == 4'h9);
  assign wr_ctrl   = reg_wr & (word == 4'hA);
  assign w1c_tick  = reg_wr & (word == 4'hB) & d_t_mem[0];
  assign w1c_ovf   = reg_wr & (word == 4'hD) & d_t_mem[0];
  assign w1c_err   = reg_wr & (word == 4'hF) & d_t_mem[0];

  // ---------------------------------------------------------------- scratch
  logic [31:0] scr_q [N_SCR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SCR; k++) scr_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_SCR; k++) begin
        if (reg_wr && (word == 4'(k))) scr_q[k] <= d_t_mem;
      end
    end
  end

  // ---------------------------------------------------------------- timer
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q;
  logic [1:0]  ctrl_q;
  logic        tick_q, tick_d;
  logic        tick_set;

  always_comb begin
    cnt_d    = cnt_q;
    tick_set = 1'b0;
    if (wr_period) begin
      cnt_d = '0;
    end else if (period_q == '0) begin
      cnt_d = '0;
    end else if (ctrl_q[0]) begin
      if (cnt_q == period_q) begin
        cnt_d    = '0;
        tick_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    tick_d = tick_set | (tick_q & ~w1c_tick);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= TMR_RST_PERIOD;
      ctrl_q   <= 2'b01;
      tick_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      if (wr_period) period_q <= d_t_mem;
      if (wr_ctrl)   ctrl_q   <= d_t_mem[1:0];
    end
  end

  assign tick_irq = tick_q & ctrl_q[1];

  // ---------------------------------------------------------------- keyboard FIFO
  logic [7:0]    kf_mem [KF_DEPTH];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] kcnt_q, kcnt_d;
  logic          ovf_q, ovf_d;
  logic          kd_rd_q;
  logic          full, nonempty, push, pop, ovf_set;
  logic [7:0]    head;

  assign full     = (kcnt_q == CW'(KF_DEPTH));
  assign nonempty = (kcnt_q != '0);
  // Pop only on the first cycle of a KDATA read so a stretched access consumes one byte.
  assign pop      = kd_rd & ~kd_rd_q & nonempty;
  assign push     = key_valid & (~full | pop);
  assign ovf_set  = key_valid & full & ~pop;
  assign head     = nonempty ? kf_mem[rptr_q] : 8'h00;

  always_comb begin
    kcnt_d = kcnt_q;
    case ({push, pop})
      2'b10:   kcnt_d = kcnt_q + CW'(1);
      2'b01:   kcnt_d = kcnt_q - CW'(1);
      default: kcnt_d = kcnt_q;
    endcase
    ovf_d = ovf_set | (ovf_q & ~w1c_ovf);
  end

  always_ff @(posedge clk) begin
    if (push) kf_mem[wptr_q] <= key_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      kcnt_q  <= '0;
      ovf_q   <= 1'b0;
      kd_rd_q <= 1'b0;
    end else begin
      kcnt_q  <= kcnt_d;
      ovf_q   <= ovf_d;
      kd_rd_q <= kd_rd;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  assign key_ready = ~full;

  // ---------------------------------------------------------------- bus error
  logic        err_q, err_d;
  logic [31:0] eaddr_q;
  logic        err_set;

  assign err_set = (wmem | rmem) & miss;
  assign err_d   = err_set | (err_q & ~w1c_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_set && !err_q) eaddr_q <= mem_a;
    end
  end

  assign bus_err = err_q;

  // ---------------------------------------------------------------- read data
  logic [31:0] reg_rdata;

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < N_SCR; k++) begin
      if (word == 4'(k)) reg_rdata = scr_q[k];
    end
    case (word)
      4'h8:    reg_rdata = cnt_q;
      4'h9:    reg_rdata = period_q;
      4'hA:    reg_rdata = {30'h0, ctrl_q};
      4'hB:    reg_rdata = {31'h0, tick_q};
      4'hC:    reg_rdata = {23'h0, nonempty, head};
      4'hD:    reg_rdata = {16'h0, 8'(kcnt_q), 6'h0, full, ovf_q};
      4'hE:    reg_rdata = eaddr_q;
      4'hF:    reg_rdata = {31'h0, err_q};
      default: ;
    endcase
  end

  always_comb begin
    d_f_mem = '0;
    if (reg_hit) begin
      d_f_mem = reg_rdata;
    end else begin
      for (int i = 0; i < N_SLV; i++) begin
        if (win[i]) d_f_mem = slv_rd[32*i +: 32];
      end
    end
  end

endmodule
